// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready load port and shifts it
// out one bit per shift_en cycle, MSB-first or LSB-first. All serial
// outputs are registered.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   load_valid  in   load_data holds a word this cycle
//   load_data   in   WIDTH-bit word to serialize
//   load_ready  out  a word is taken this cycle if load_valid is high
//   shift_en    in   bit-rate enable; the frame advances only when high
//   ser_out     out  current serial bit (0 when not in a frame)
//   ser_valid   out  ser_out carries a frame bit
//   frame_done  out  one-cycle pulse while the last bit of a frame is first shown
//   busy        out  FSM is in SHIFT (also serves as the state debug view)
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both 1; load_data is sampled only at that edge. load_ready
// is combinational: high in IDLE, and high in SHIFT only on the cycle the
// last bit is being retired (bits_left=0, shift_en=1), so a new frame can
// follow with no gap. load_valid while load_ready=0 is ignored.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bits_left_q, bits_left_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_done_q, frame_done_d;

  logic             last_bit;
  logic             accept;
  logic             load_first;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // The shift register always holds the not-yet-sent bits aligned so the
  // next one to send sits at the outgoing end (MSB or LSB).
  always_comb begin
    if (MSB_FIRST != 0) begin
      load_first = load_data[WIDTH-1];
      load_rest  = load_data << 1;
      next_bit   = shreg_q[WIDTH-1];
      shreg_adv  = shreg_q << 1;
    end else begin
      load_first = load_data[0];
      load_rest  = load_data >> 1;
      next_bit   = shreg_q[0];
      shreg_adv  = shreg_q >> 1;
    end
  end

  assign last_bit   = (bits_left_q == '0);
  assign load_ready = (state_q == IDLE) || (last_bit && shift_en);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    shreg_d      = shreg_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // shift_en has no effect here; only an accept starts a frame.
        if (accept) begin
          state_d     = SHIFT;
          bits_left_d = CW'(WIDTH - 1);
          shreg_d     = load_rest;
          ser_out_d   = load_first;
          ser_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!last_bit) begin
            bits_left_d  = bits_left_q - 1'b1;
            shreg_d      = shreg_adv;
            ser_out_d    = next_bit;
            // The bit now being presented is the last one of the frame.
            frame_done_d = (bits_left_q == CW'(1));
          end else if (accept) begin
            // Last bit retired and a new word taken: no gap cycle.
            bits_left_d = CW'(WIDTH - 1);
            shreg_d     = load_rest;
            ser_out_d   = load_first;
            ser_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            shreg_d     = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        bits_left_d = '0;
        shreg_d     = '0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      shreg_q      <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      shreg_q      <= shreg_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: one MSB-first and one LSB-first instance (WIDTH=8)
// share the same stimulus. Each expected queue entry is
// {last_of_frame, lsb_first_bit, msb_first_bit}; entries are pushed when a
// word is accepted and popped when a bit is retired with shift_en=1.
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;

  logic ready_m, out_m, valid_m, fd_m, busy_m;
  logic ready_l, out_l, valid_l, fd_l, busy_l;

  logic [2:0] exp_q[$];
  logic [2:0] mon_f;
  logic       mon_ready_exp;
  logic       mon_pop;
  logic       mon_acc;
  logic       fresh;

  int checks;
  int errors;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_m),
    .shift_en   (shift_en),
    .ser_out    (out_m),
    .ser_valid  (valid_m),
    .frame_done (fd_m),
    .busy       (busy_m)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_l),
    .shift_en   (shift_en),
    .ser_out    (out_l),
    .ser_valid  (valid_l),
    .frame_done (fd_l),
    .busy       (busy_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outs();
    check_eq("rst_valid_m", valid_m, 1'b0);
    check_eq("rst_out_m",   out_m,   1'b0);
    check_eq("rst_fd_m",    fd_m,    1'b0);
    check_eq("rst_busy_m",  busy_m,  1'b0);
    check_eq("rst_ready_m", ready_m, 1'b1);
    check_eq("rst_valid_l", valid_l, 1'b0);
    check_eq("rst_out_l",   out_l,   1'b0);
    check_eq("rst_fd_l",    fd_l,    1'b0);
    check_eq("rst_busy_l",  busy_l,  1'b0);
    check_eq("rst_ready_l", ready_l, 1'b1);
  endtask

  // scoreboard / monitor: compares on the falling edge, then advances the
  // model by what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fresh = 1'b0;
    end else begin
      mon_ready_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && shift_en);
      check_eq("valid_m", valid_m, exp_q.size() != 0);
      check_eq("valid_l", valid_l, exp_q.size() != 0);
      check_eq("busy_m",  busy_m,  exp_q.size() != 0);
      check_eq("busy_l",  busy_l,  exp_q.size() != 0);
      check_eq("ready_m", ready_m, mon_ready_exp);
      check_eq("ready_l", ready_l, mon_ready_exp);
      if (exp_q.size() != 0) begin
        mon_f = exp_q[0];
        check_eq("bit_m", out_m, mon_f[0]);
        check_eq("bit_l", out_l, mon_f[1]);
        check_eq("done_m", fd_m, mon_f[2] && fresh);
        check_eq("done_l", fd_l, mon_f[2] && fresh);
      end else begin
        check_eq("idle_out_m", out_m, 1'b0);
        check_eq("idle_out_l", out_l, 1'b0);
        check_eq("idle_done_m", fd_m, 1'b0);
        check_eq("idle_done_l", fd_l, 1'b0);
      end
      mon_pop = (exp_q.size() != 0) && shift_en;
      mon_acc = load_valid && mon_ready_exp;
      if (mon_pop) void'(exp_q.pop_front());
      if (mon_acc) begin
        for (int i = 0; i < 8; i++)
          exp_q.push_back({(i == 7), load_data[i], load_data[7-i]});
      end
      fresh = mon_pop || mon_acc;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    logic acc;
    acc        = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = ready_m;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    if (!acc) check_eq("load_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    shift_en = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step(1);
    check_eq("drain", exp_q.size() == 0, 1'b1);
    step(2);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fresh      = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    shift_en   = 1'b1;

    #2;
    check_reset_outs();
    step(2);

    // first accept on the first edge after release
    rst = 1'b0;
    load_word(8'hA5);
    drain();

    load_word(8'h0F);
    drain();

    // back-to-back: second word held valid until the last-bit cycle
    load_word(8'hFF);
    load_word(8'h00);
    drain();

    // stall three cycles after the 2nd bit
    load_word(8'hC3);
    step(1);
    shift_en = 1'b0;
    step(3);
    shift_en = 1'b1;
    drain();

    // load attempted mid-frame must be ignored
    load_word(8'hA5);
    step(2);
    load_valid = 1'b1;
    load_data  = 8'h55;
    step(2);
    load_valid = 1'b0;
    drain();

    // asynchronous reset after the 4th bit
    load_word(8'hA5);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs();
    step(2);
    rst = 1'b0;
    load_word(8'h3C);
    drain();

    // random traffic with random bit-rate enable
    for (int n = 0; n < 300; n++) begin
      shift_en   = ($urandom_range(0, 3) != 0);
      load_valid = ($urandom_range(0, 1) != 0);
      load_data  = 8'($urandom_range(0, 255));
      step(1);
    end
    load_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
